// File: rtl/seq_pack_pkg.sv
// Shared defaults and entry layout for the sequential-stage word packer.
// Optional checksum support is enabled with SEQ_PACK_CHECKSUM_EN.
package seq_pack_pkg;

  localparam int DATA_W_D = 8;
  localparam int LANES_D  = 4;
  localparam int DEPTH_D  = 2;
  localparam int CNT_W    = $clog2(LANES_D) + 1;

  typedef struct packed {
    logic [DATA_W_D*LANES_D-1:0] data;
    logic [CNT_W-1:0]            count;
`ifdef SEQ_PACK_CHECKSUM_EN
    logic [DATA_W_D-1:0]         csum;
`endif
  } entry_t;

endpackage

// File: rtl/seq_pack_fifo.sv
// Generic circular buffer with occupancy counter; pop frees a slot
// in the same edge so push-while-full succeeds when a pop coincides.
module seq_pack_fifo
  import seq_pack_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEPTH_D
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [OW-1:0] occ;
  logic          do_push;
  logic          do_pop;

  assign full    = occ == OW'(DEPTH);
  assign empty   = occ == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty buffer presents zero rather than stale storage.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/seq_word_packer.sv
// Packs sequential-stage samples into LANES-wide words behind a small buffer.
// Define SEQ_PACK_CHECKSUM_EN to add per-word XOR checksum outputs.
module seq_word_packer
  import seq_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int LANES  = LANES_D,
  parameter int DEPTH  = DEPTH_D
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [DATA_W*LANES-1:0]   out_data,
  output logic [$clog2(LANES):0]    out_count,
  input  logic                      out_ready,
  output logic                      overflow
`ifdef SEQ_PACK_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]         out_csum,
  output logic                      csum_zero_seen
`endif
);

  localparam int LW = $clog2(LANES);
  localparam int CW = LW + 1;

  typedef struct packed {
    logic [DATA_W*LANES-1:0] data;
    logic [CW-1:0]           count;
`ifdef SEQ_PACK_CHECKSUM_EN
    logic [DATA_W-1:0]       csum;
`endif
  } ent_t;

  logic [LW-1:0]           cnt;
  logic [DATA_W*LANES-1:0] pack;
  logic [DATA_W*LANES-1:0] pack_nxt;
  logic                    pend;
  logic                    pend_nxt;
  logic                    buf_full;
  logic                    buf_empty;
  logic                    last;
  logic                    acc;
  logic                    drop;
  logic                    pop;
  logic                    push;
  logic                    space;
  logic                    fl;
  logic [CW-1:0]           fill;
  ent_t                    wr;
  ent_t                    rd;

  assign last     = cnt == LW'(LANES - 1);
  assign in_ready = !(last && buf_full) && !pend;
  assign acc      = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;
  assign pop      = out_valid && out_ready;
  assign space    = !buf_full || pop;
  assign fl       = flush || pend;
  assign fill     = CW'(cnt) + CW'(acc);

  always_comb begin
    pack_nxt = pack;
    if (acc) pack_nxt[cnt*DATA_W +: DATA_W] = in_data;
  end

  // A completing sample always pushes; otherwise a flush pushes when
  // there is data and room, else it waits.
  always_comb begin
    push     = 1'b0;
    pend_nxt = pend;
    if (acc && last) begin
      push     = 1'b1;
      pend_nxt = 1'b0;
    end else if (fl) begin
      if (fill == '0) begin
        pend_nxt = 1'b0;
      end else if (space) begin
        push     = 1'b1;
        pend_nxt = 1'b0;
      end else begin
        pend_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    wr       = '0;
    wr.data  = pack_nxt;
    wr.count = fill;
`ifdef SEQ_PACK_CHECKSUM_EN
    for (int i = 0; i < LANES; i++)
      wr.csum = wr.csum ^ pack_nxt[i*DATA_W +: DATA_W];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      pack     <= '0;
      pend     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (drop) overflow <= 1'b1;
      if (push) begin
        cnt  <= '0;
        pack <= '0;
      end else if (acc) begin
        cnt  <= cnt + LW'(1);
        pack <= pack_nxt;
      end
    end
  end

`ifdef SEQ_PACK_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      csum_zero_seen <= 1'b0;
    else if (push && wr.csum == '0)
      csum_zero_seen <= 1'b1;
  end

  assign out_csum = rd.csum;
`endif

  seq_pack_fifo #(
    .W     ($bits(ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr),
    .rdata (rd),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign out_valid = !buf_empty;
  assign out_data  = rd.data;
  assign out_count = rd.count;

endmodule

// File: tb/tb_seq_word_packer.sv
// Bench for seq_word_packer: directed scenarios plus random traffic
// checked against a queue-based model of the packer.
module tb_seq_word_packer;

  localparam int L = 4;
  localparam int D = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        overflow;
`ifdef SEQ_PACK_CHECKSUM_EN
  logic [7:0]  out_csum;
  logic        csum_zero_seen;
`endif

  always #5 clock = ~clock;

  seq_word_packer dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready),
    .overflow  (overflow)
`ifdef SEQ_PACK_CHECKSUM_EN
    ,
    .out_csum       (out_csum),
    .csum_zero_seen (csum_zero_seen)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  part [$];
  logic [31:0] mq_d [$];
  int          mq_c [$];
  logic [7:0]  mq_s [$];
  bit          m_pend;
  bit          m_ovf;
  bit          m_cz;

  function automatic void mreset();
    part.delete();
    mq_d.delete();
    mq_c.delete();
    mq_s.delete();
    m_pend = 0;
    m_ovf  = 0;
    m_cz   = 0;
  endfunction

  function automatic void emit();
    logic [31:0] w;
    logic [7:0]  s;
    w = '0;
    s = '0;
    foreach (part[i]) begin
      w[8*i +: 8] = part[i];
      s = s ^ part[i];
    end
    mq_d.push_back(w);
    mq_c.push_back(part.size());
    mq_s.push_back(s);
    if (s == 8'h00) m_cz = 1;
    part.delete();
  endfunction

  task automatic step(bit v, logic [7:0] d, bit f, bit r);
    bit rdy;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
    rdy = !((part.size() == L-1 && mq_d.size() == D) || m_pend);
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, mq_d.size() > 0);
    if (mq_d.size() > 0) begin
      check("out_data", out_data, mq_d[0]);
      check("out_count", out_count, mq_c[0]);
`ifdef SEQ_PACK_CHECKSUM_EN
      check("out_csum", out_csum, mq_s[0]);
`endif
    end
    check("overflow", overflow, m_ovf);
`ifdef SEQ_PACK_CHECKSUM_EN
    check("csum_zero_seen", csum_zero_seen, m_cz);
`endif
    if (r && mq_d.size() > 0) begin
      void'(mq_d.pop_front());
      void'(mq_c.pop_front());
      void'(mq_s.pop_front());
    end
    if (v && rdy) part.push_back(d);
    else if (v) m_ovf = 1;
    if (part.size() == L) begin
      emit();
      m_pend = 0;
    end else if (f || m_pend) begin
      if (part.size() == 0) m_pend = 0;
      else if (mq_d.size() < D) begin
        emit();
        m_pend = 0;
      end else m_pend = 1;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    mreset();
    repeat (2) @(negedge clock);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    step(1, 8'h01, 0, 1);
    step(1, 8'h03, 0, 1);
    step(1, 8'h0C, 0, 1);
    step(1, 8'h14, 0, 1);
    #1;
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 32'h140C0301);
    check("t1_count", out_count, 4);
    step(0, 8'h00, 0, 1);

    step(1, 8'h12, 0, 1);
    step(1, 8'h07, 0, 1);
    step(0, 8'h00, 1, 1);
    #1;
    check("t2_data", out_data, 32'h00000712);
    check("t2_count", out_count, 2);
    step(1, 8'h04, 0, 1);
    step(0, 8'h00, 1, 1);
    #1;
    check("t2_lane0", out_data, 32'h00000004);
    check("t2_cnt1", out_count, 1);
    step(0, 8'h00, 0, 1);

    for (int i = 0; i < 12; i++) step(1, 8'(8'h20 + i), 0, 0);
    #1;
    check("t3_ovf", overflow, 1);
    check("t3_ready", in_ready, 0);
    check("t3_head", out_data, 32'h23222120);
    step(0, 8'h00, 0, 1);
    #1;
    check("t3_second", out_data, 32'h27262524);
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);
    #1;
    check("t3_ovf_hold", overflow, 1);

    for (int i = 0; i < 10; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);
    #1;
    check("t4_third", out_data, 32'h00004948);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    for (int i = 0; i < 6; i++) step(1, 8'(8'h60 + i), 0, 0);
    reset = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_ovf", overflow, 0);
    mreset();
    @(negedge clock);
    reset = 1'b0;
    step(1, 8'hA1, 0, 1);
    step(1, 8'hB2, 0, 1);
    step(1, 8'hC3, 0, 1);
    step(1, 8'hD4, 0, 1);
    #1;
    check("t5_word", out_data, 32'hD4C3B2A1);
    step(0, 8'h00, 0, 1);

`ifdef SEQ_PACK_CHECKSUM_EN
    step(1, 8'h0F, 0, 1);
    step(1, 8'hF0, 0, 1);
    step(1, 8'hFF, 0, 1);
    step(1, 8'h00, 0, 1);
    #1;
    check("cs_val", out_csum, 8'h00);
    check("cs_seen", csum_zero_seen, 1);
    step(0, 8'h00, 0, 1);
`endif

    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
